// File: rtl/llfifo_ptr_alloc.sv
// -----------------------------------------------------------------------------
// llfifo_ptr_alloc
//   Free-pointer allocator for the linked-list multi-queue FIFO. It hands out
//   unused entry pointers for pushes and recycles the pointers released by pops.
//   Pointer 0 is the null terminator and is never handed out. The usable
//   pointers 1..PTR_N-1 live in a circular free-list buffer of depth PTR_N-1.
//   After reset the buffer fills itself with one pointer per cycle (busy=1).
//
// Optional feature macro: LLFIFO_PTR_ALLOC_CHECK_EN
//   Defined     : an in-use bitmap catches double frees; they are dropped and
//                 set err[2].
//   Not defined : no bitmap and err[2] is tied 0. A double free is accepted and
//                 corrupts the list, so the caller must not do it.
//
// Ports
//   clk        in   1      sole clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   busy       out  1      1 while the free list is initialising
//   alloc_rdy  out  1      a free pointer is available on alloc_ptr
//   alloc_ptr  out  PTR_W  pointer granted when alloc_en & alloc_rdy
//   alloc_en   in   1      consumer takes alloc_ptr this cycle
//   free_en    in   1      return free_ptr to the free list
//   free_ptr   in   PTR_W  pointer being released
//   free_cnt   out  PTR_W  number of pointers currently free
//   err        out  3      sticky: [0] free overflow, [1] illegal ptr,
//                          [2] double free
// -----------------------------------------------------------------------------
module llfifo_ptr_alloc #(
  parameter int PTR_N = 255,
  parameter int PTR_W = $clog2(PTR_N)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             busy,
  output logic             alloc_rdy,
  output logic [PTR_W-1:0] alloc_ptr,
  input  logic             alloc_en,
  input  logic             free_en,
  input  logic [PTR_W-1:0] free_ptr,
  output logic [PTR_W-1:0] free_cnt,
  output logic [2:0]       err
);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(PTR_N - 2);  // last buffer slot
  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(PTR_N - 1);  // all pointers free
  localparam logic [PTR_W:0]   PTR_LIM  = (PTR_W + 1)'(PTR_N);

  state_t           state_r;
  logic             busy_r;
  logic [PTR_W-1:0] rd_r;
  logic [PTR_W-1:0] wr_r;
  logic [PTR_W-1:0] init_cnt_r;
  logic [PTR_W-1:0] free_cnt_r;
  logic [2:0]       err_r;
  logic [PTR_W-1:0] mem_r [0:PTR_N-2];

  logic             ready_s;
  logic             rdy_s;
  logic             grant_s;
  logic             illegal_s;
  logic             ovf_s;
  logic             dbl_s;
  logic             legal_s;
  logic             we_s;
  logic [PTR_W-1:0] wdata_s;
  logic [PTR_W-1:0] rd_nxt_s;
  logic [PTR_W-1:0] wr_nxt_s;

`ifdef LLFIFO_PTR_ALLOC_CHECK_EN
  logic [(2**PTR_W)-1:0] inuse_r;
`endif

  // Decode grant/free legality and the single buffer write port.
  always_comb begin
    ready_s   = 1'b0;
    rdy_s     = 1'b0;
    grant_s   = 1'b0;
    illegal_s = 1'b0;
    ovf_s     = 1'b0;
    dbl_s     = 1'b0;
    legal_s   = 1'b0;
    we_s      = 1'b0;
    wdata_s   = '0;
    rd_nxt_s  = (rd_r == LAST_IDX) ? '0 : rd_r + PTR_W'(1);
    wr_nxt_s  = (wr_r == LAST_IDX) ? '0 : wr_r + PTR_W'(1);
    illegal_s = free_en && ((free_ptr == '0) || ({1'b0, free_ptr} >= PTR_LIM));
    if (state_r == ST_READY) begin
      ready_s = 1'b1;
      rdy_s   = (free_cnt_r != '0);
      grant_s = alloc_en && rdy_s;
      // A same-cycle grant makes room, so a free into a full list is fine then.
      ovf_s   = free_en && !illegal_s && (free_cnt_r == FULL_CNT) && !grant_s;
`ifdef LLFIFO_PTR_ALLOC_CHECK_EN
      dbl_s   = free_en && !illegal_s && !inuse_r[free_ptr];
`else
      dbl_s   = 1'b0;
`endif
      legal_s = free_en && !illegal_s && !ovf_s && !dbl_s;
      we_s    = legal_s;
      wdata_s = free_ptr;
    end else begin
      // Initialisation writes the next pointer value every cycle.
      we_s    = 1'b1;
      wdata_s = init_cnt_r;
    end
  end

  // Free-list storage; contents are only meaningful behind rd/wr.
  always_ff @(posedge clk) begin
    if (we_s && !rst) begin
      mem_r[wr_r] <= wdata_s;
    end
  end

  // Control FSM: self-initialisation, rd/wr indices, free count, sticky errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_INIT;
      busy_r     <= 1'b1;
      rd_r       <= '0;
      wr_r       <= '0;
      init_cnt_r <= PTR_W'(1);
      free_cnt_r <= '0;
      err_r      <= 3'b000;
    end else begin
      case (state_r)
        ST_INIT: begin
          wr_r       <= wr_nxt_s;
          free_cnt_r <= free_cnt_r + PTR_W'(1);
          init_cnt_r <= init_cnt_r + PTR_W'(1);
          // Frees are not accepted while the list is being built.
          if (free_en) begin
            err_r[1] <= 1'b1;
          end
          if (init_cnt_r == FULL_CNT) begin
            state_r <= ST_READY;
            busy_r  <= 1'b0;
          end
        end
        ST_READY: begin
          if (grant_s) begin
            rd_r <= rd_nxt_s;
          end
          if (legal_s) begin
            wr_r <= wr_nxt_s;
          end
          free_cnt_r <= free_cnt_r + PTR_W'(legal_s) - PTR_W'(grant_s);
          err_r      <= err_r | {dbl_s, illegal_s, ovf_s};
        end
        default: begin
          state_r <= ST_INIT;
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

`ifdef LLFIFO_PTR_ALLOC_CHECK_EN
  // In-use bitmap: set on grant, cleared on legal free (never the same ptr).
  always_ff @(posedge clk) begin
    if (rst) begin
      inuse_r <= '0;
    end else begin
      if (grant_s) begin
        inuse_r[alloc_ptr] <= 1'b1;
      end
      if (legal_s) begin
        inuse_r[free_ptr] <= 1'b0;
      end
    end
  end
`endif

  assign busy      = busy_r;
  assign alloc_rdy = rdy_s;
  // Head of the free list, combinational from registered state for 0-latency grant.
  assign alloc_ptr = ready_s ? mem_r[rd_r] : '0;
  assign free_cnt  = free_cnt_r;
  assign err       = err_r;

endmodule
